fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
Parametrised successor to the fixed two-source forwarding logic. It tracks in-flight register writes in a NUM_FWD-deep shift scoreboard that mirrors the stages after EX1. From that it generates per-operand forwarding selects for EX1 and a load-use stall request for ID. Load-result readiness is configurable, and the block adds a sticky hazard-error flag and optional performance counters.

Parameters:
REG_ADDR_W, 4, register index width; index 0 is the hard-wired zero register and is never forwarded.
NUM_FWD, 3, number of tracked slots after EX1 (slot 1 = EX2, slot 2 = MEM, slot 3 = WB).
LOAD_READY_SLOT, 2, first slot whose load result is forwardable; legal range 1..NUM_FWD.
SEL_W, $clog2(NUM_FWD+1), width of each forwarding select.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
advance  in  1  pipeline moves this cycle; 0 freezes the scoreboard
flush  in  1  kill the instruction currently in EX1
ex_valid  in  1  EX1 holds a valid instruction
ex_reg_write  in  1  EX1 instruction writes rd
ex_is_load  in  1  EX1 instruction is a load
ex_rd  in  REG_ADDR_W  EX1 destination
ex_rs1  in  REG_ADDR_W  EX1 source A
ex_rs2  in  REG_ADDR_W  EX1 source B
id_valid  in  1  ID holds a valid instruction
id_rs1  in  REG_ADDR_W  ID source A
id_rs2  in  REG_ADDR_W  ID source B
forward_a  out  SEL_W  0 = register-file or ID/EX value; k = forward from slot k
forward_b  out  SEL_W  same encoding, for source B
stall  out  1  hold IF/ID and insert a bubble into EX1
hazard_err  out  1  sticky: EX1 consumed a load result that was not yet forwardable
stall_cycles  out  16  saturating stall count (see Optional Feature)
fwd_count  out  16  saturating count of nonzero forward selects

Behaviour:
- Reset is asynchronous and active-low.
  - All slots go invalid.
  - hazard_err, stall_cycles and fwd_count go to 0.
  - forward_a, forward_b and stall read 0 while reset is held.
- Slot contents: valid, reg_write, is_load, rd.
- On a clk edge with advance=1:
  - slot k+1 <= slot k.
  - slot 1 <= {ex_valid & ~flush, ex_reg_write, ex_is_load, ex_rd}.
  - The entry leaving slot NUM_FWD is discarded.
- advance=0: slots hold. flush has no effect on the scoreboard that cycle.
- Slot k is a live producer for register r when: valid & reg_write & rd==r & r!=0.
- forward_a and forward_b are combinational from registered slots and ex_rs*; zero-cycle latency.
  - Select = the lowest-numbered (youngest) live producer slot, else 0.
  - If that youngest slot is a load in slot k < LOAD_READY_SLOT: select it anyway and set hazard_err on the next edge, only when advance=1 and ex_valid=1.
  - hazard_err clears only on reset.
- stall is combinational: id_valid & ~flush & (load-use hazard). The hazard exists for id_rs1 or id_rs2 (nonzero) when either:
  - EX1 holds a live load producing that register and LOAD_READY_SLOT > 1; or
  - slot k holds the youngest live producer, it is a load, and k+1 < LOAD_READY_SLOT.
- A younger non-load producer of the same register masks an older load; no stall in that case.
- Multi-cycle stall: the bubble enters as slot 1 invalid each advance, and stall drops once the load reaches slot LOAD_READY_SLOT-1.
- Both operands are evaluated independently. rs1==rs2 yields identical selects.
- Reset mid-stall: stall drops immediately and the scoreboard is empty.

Optional Feature:
Macro FWD_PERF_EN.
- Defined: on each clk edge with advance=1, stall_cycles increments when stall=1, and fwd_count increments once per nonzero select (0, 1 or 2 per cycle). Both counters saturate at 16'hFFFF.
- Not defined: stall_cycles and fwd_count are tied to 0 and no counter flops are built.

Decomposition:
- Package fwd_pkg holds:
  - the slot typedef (valid, reg_write, is_load, rd);
  - constant FWD_NONE = 0;
  - the zero-register index constant;
  - a helper function for the select width.
- One sub-module, fwd_match_sel: priority match of one source index against all slots, returning the select and the load-not-ready flag. It is instantiated twice for EX1 (A, B) and reused for ID hazard detection.

Test Plan:
- Defaults. ALU writes r3; next instruction reads ex_rs1=3 with the producer in slot 1 -> forward_a=1, forward_b=0, stall=0.
- Producer priority. r5 is written in slots 1 and 2 -> forward_a=1; with slot 1 invalidated by flush -> forward_a=2.
- Load-use stall. Load r4 in EX1, id_rs2=4, LOAD_READY_SLOT=2 -> stall=1 for exactly 1 cycle. In the following cycle, forward_b=2 once the dependent instruction reaches EX1.
- LOAD_READY_SLOT=3 with load r4 in EX1 -> 2 stall cycles. A non-load write to r4 sitting in slot 1 (younger than the load) -> no stall.
- Zero register and freeze. ex_rs1=0 with a slot writing r0 -> forward_a=0. advance=0 for 5 cycles -> slots and selects unchanged. Asserting rst_n=0 mid-stall -> stall=0 and the scoreboard is empty.
- Forced hazard. Drive a dependent EX1 instruction against an unready load in slot 1 -> hazard_err=1 and it stays set. With FWD_PERF_EN, 3 stall cycles -> stall_cycles=3.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared slot type, constants and helpers for the forwarding scoreboard.
// Register indices are held zero-extended to MaxRegAddrW bits inside slots.
package fwd_pkg;

  localparam int unsigned MaxRegAddrW = 8;
  localparam int unsigned FWD_NONE    = 0;
  localparam int unsigned ZERO_REG    = 0;

  typedef struct packed {
    logic                   valid;
    logic                   reg_write;
    logic                   is_load;
    logic [MaxRegAddrW-1:0] rd;
  } slot_t;

  function automatic int unsigned sel_width(input int unsigned num_slots);
    return $clog2(num_slots + 1);
  endfunction

endpackage

// File: rtl/fwd_match_sel.sv
// Priority match of one source register against an ordered set of producer slots.
// Returns the youngest live producer (1-based) and whether it is a load not yet forwardable.
module fwd_match_sel
  import fwd_pkg::*;
#(
  parameter int unsigned NumSlots      = 3,
  parameter int unsigned LoadReadySlot = 2,
  parameter int unsigned SelW          = sel_width(NumSlots)
) (
  input  logic [MaxRegAddrW-1:0] src_i,
  input  slot_t                  slots_i [NumSlots],
  output logic [SelW-1:0]        sel_o,
  output logic                   not_ready_o
);

  logic src_nonzero;

  assign src_nonzero = (src_i != MaxRegAddrW'(ZERO_REG));

  always_comb begin
    sel_o       = SelW'(FWD_NONE);
    not_ready_o = 1'b0;
    // Walk oldest to youngest so the youngest live producer has the last word.
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (slots_i[i].valid && slots_i[i].reg_write && src_nonzero &&
          (slots_i[i].rd == src_i)) begin
        sel_o       = SelW'(i + 1);
        not_ready_o = slots_i[i].is_load && (32'(i + 1) < LoadReadySlot);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Shift scoreboard of in-flight writes after EX1, producing EX1 forward selects, ID load-use
// stall and a sticky hazard flag. Define FWD_PERF_EN to build the stall/forward counters.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W      = 4,
  parameter int unsigned NUM_FWD         = 3,
  parameter int unsigned LOAD_READY_SLOT = 2,
  parameter int unsigned SEL_W           = sel_width(NUM_FWD)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  advance,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic [SEL_W-1:0]      forward_a,
  output logic [SEL_W-1:0]      forward_b,
  output logic                  stall,
  output logic                  hazard_err,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           fwd_count
);

  localparam int unsigned IdSelW = sel_width(NUM_FWD + 1);

  slot_t slots_q [NUM_FWD];
  slot_t ex_entry;
  slot_t ex_entry_kill;
  slot_t id_view [NUM_FWD + 1];

  logic [MaxRegAddrW-1:0] ex_rs1_ext, ex_rs2_ext, id_rs1_ext, id_rs2_ext;
  logic                   ex_nr_a, ex_nr_b;
  logic [IdSelW-1:0]      id_sel_a, id_sel_b;
  logic                   id_nr_a, id_nr_b;
  logic                   id_hz_a, id_hz_b;
  logic                   hazard_err_q;

  assign ex_rs1_ext = MaxRegAddrW'(ex_rs1);
  assign ex_rs2_ext = MaxRegAddrW'(ex_rs2);
  assign id_rs1_ext = MaxRegAddrW'(id_rs1);
  assign id_rs2_ext = MaxRegAddrW'(id_rs2);

  always_comb begin
    ex_entry.valid     = ex_valid;
    ex_entry.reg_write = ex_reg_write;
    ex_entry.is_load   = ex_is_load;
    ex_entry.rd        = MaxRegAddrW'(ex_rd);
    ex_entry_kill       = ex_entry;
    ex_entry_kill.valid = ex_valid & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_FWD; k++) begin
        slots_q[k] <= '0;
      end
    end else if (advance) begin
      slots_q[0] <= ex_entry_kill;
      for (int k = 1; k < NUM_FWD; k++) begin
        slots_q[k] <= slots_q[k-1];
      end
    end
  end

  fwd_match_sel #(
    .NumSlots      (NUM_FWD),
    .LoadReadySlot (LOAD_READY_SLOT),
    .SelW          (SEL_W)
  ) u_match_ex_a (
    .src_i       (ex_rs1_ext),
    .slots_i     (slots_q),
    .sel_o       (forward_a),
    .not_ready_o (ex_nr_a)
  );

  fwd_match_sel #(
    .NumSlots      (NUM_FWD),
    .LoadReadySlot (LOAD_READY_SLOT),
    .SelW          (SEL_W)
  ) u_match_ex_b (
    .src_i       (ex_rs2_ext),
    .slots_i     (slots_q),
    .sel_o       (forward_b),
    .not_ready_o (ex_nr_b)
  );

  // ID sees EX1 as position 1 and slot k as position k+1, so an entry at position p blocks
  // the ID instruction exactly when p < LOAD_READY_SLOT.
  always_comb begin
    id_view[0] = ex_entry;
    for (int k = 0; k < NUM_FWD; k++) begin
      id_view[k+1] = slots_q[k];
    end
  end

  fwd_match_sel #(
    .NumSlots      (NUM_FWD + 1),
    .LoadReadySlot (LOAD_READY_SLOT),
    .SelW          (IdSelW)
  ) u_match_id_a (
    .src_i       (id_rs1_ext),
    .slots_i     (id_view),
    .sel_o       (id_sel_a),
    .not_ready_o (id_nr_a)
  );

  fwd_match_sel #(
    .NumSlots      (NUM_FWD + 1),
    .LoadReadySlot (LOAD_READY_SLOT),
    .SelW          (IdSelW)
  ) u_match_id_b (
    .src_i       (id_rs2_ext),
    .slots_i     (id_view),
    .sel_o       (id_sel_b),
    .not_ready_o (id_nr_b)
  );

  assign id_hz_a = id_nr_a & (id_sel_a != IdSelW'(FWD_NONE));
  assign id_hz_b = id_nr_b & (id_sel_b != IdSelW'(FWD_NONE));

  // Gated by rst_n so a held reset never requests a stall from live EX1 inputs.
  assign stall = rst_n & id_valid & ~flush & (id_hz_a | id_hz_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_err_q <= 1'b0;
    end else if (advance && ex_valid && (ex_nr_a || ex_nr_b)) begin
      hazard_err_q <= 1'b1;
    end
  end

  assign hazard_err = hazard_err_q;

`ifdef FWD_PERF_EN
  logic [15:0] stall_cycles_q;
  logic [15:0] fwd_count_q;
  logic [1:0]  fwd_inc;
  logic [16:0] fwd_sum;

  assign fwd_inc = {1'b0, (forward_a != SEL_W'(FWD_NONE))} +
                   {1'b0, (forward_b != SEL_W'(FWD_NONE))};
  assign fwd_sum = {1'b0, fwd_count_q} + {15'd0, fwd_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 16'd0;
      fwd_count_q    <= 16'd0;
    end else if (advance) begin
      if (stall && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
      fwd_count_q <= fwd_sum[16] ? 16'hFFFF : fwd_sum[15:0];
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_count    = fwd_count_q;
`else
  assign stall_cycles = 16'd0;
  assign fwd_count    = 16'd0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench: two scoreboards (load ready at slot 2 and slot 3) share one stimulus stream
// and are checked against a queue-based pipeline model of the forwarding rules.
`timescale 1ns/1ps
module tb_fwd_scoreboard;

  localparam int unsigned RW = 4;
  localparam int unsigned NF = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          advance, flush, ex_valid, ex_reg_write, ex_is_load, id_valid;
  logic [RW-1:0] ex_rd, ex_rs1, ex_rs2, id_rs1, id_rs2;
  logic [1:0]    fa2, fb2, fa3, fb3;
  logic          st2, st3, he2, he3;
  logic [15:0]   sc2, fc2, sc3, fc3;

  fwd_scoreboard #(.REG_ADDR_W(RW), .NUM_FWD(NF), .LOAD_READY_SLOT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .forward_a(fa2), .forward_b(fb2), .stall(st2), .hazard_err(he2),
    .stall_cycles(sc2), .fwd_count(fc2)
  );

  fwd_scoreboard #(.REG_ADDR_W(RW), .NUM_FWD(NF), .LOAD_READY_SLOT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .forward_a(fa3), .forward_b(fb3), .stall(st3), .hazard_err(he3),
    .stall_cycles(sc3), .fwd_count(fc3)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    bit w;
    bit l;
    int rd;
  } ent_t;

  typedef struct {
    int fa;
    int fb;
    bit st2;
    bit st3;
    bit he2;
    bit he3;
    int sc2;
    int sc3;
    int fc;
  } exp_t;

  ent_t pipe[$];   // pipe[0] is the instruction that left EX1 most recently
  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  bit   m_he2, m_he3;
  int   m_sc2, m_sc3, m_fc;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Age (1 = just left EX1) of the most recent in-flight writer of src, 0 if none.
  function automatic int youngest(input int src);
    if (src == 0) return 0;
    foreach (pipe[i]) begin
      if (pipe[i].v && pipe[i].w && pipe[i].rd == src) return i + 1;
    end
    return 0;
  endfunction

  function automatic bit unready(input int src, input int lrs);
    int k;
    k = youngest(src);
    return (k != 0) && pipe[k-1].l && (k < lrs);
  endfunction

  // The ID instruction reaches EX1 one edge later, when its producer is one slot older.
  function automatic bit load_use(input int src, input int lrs);
    int k;
    if (src == 0) return 0;
    if (ex_valid && ex_reg_write && int'(ex_rd) == src) return ex_is_load && (lrs > 1);
    k = youngest(src);
    return (k != 0) && pipe[k-1].l && (k + 1 < lrs);
  endfunction

  function automatic bit stall_exp(input int lrs);
    return id_valid && !flush && (load_use(int'(id_rs1), lrs) || load_use(int'(id_rs2), lrs));
  endfunction

  task automatic model_reset();
    ent_t e;
    e = '{v: 0, w: 0, l: 0, rd: 0};
    pipe.delete();
    repeat (NF) pipe.push_back(e);
    m_he2 = 0;
    m_he3 = 0;
    m_sc2 = 0;
    m_sc3 = 0;
    m_fc  = 0;
  endtask

  task automatic model_edge();
    ent_t e;
    int   n;
    if (!advance) return;
    if (ex_valid && (unready(int'(ex_rs1), 2) || unready(int'(ex_rs2), 2))) m_he2 = 1;
    if (ex_valid && (unready(int'(ex_rs1), 3) || unready(int'(ex_rs2), 3))) m_he3 = 1;
`ifdef FWD_PERF_EN
    if (stall_exp(2) && m_sc2 < 65535) m_sc2++;
    if (stall_exp(3) && m_sc3 < 65535) m_sc3++;
    n = m_fc + int'(youngest(int'(ex_rs1)) != 0) + int'(youngest(int'(ex_rs2)) != 0);
    m_fc = (n > 65535) ? 65535 : n;
`else
    n = 0;
`endif
    e = '{v: ex_valid && !flush, w: ex_reg_write, l: ex_is_load, rd: int'(ex_rd)};
    pipe.push_front(e);
    void'(pipe.pop_back());
  endtask

  task automatic push_exp();
    exp_t e;
    e.fa  = youngest(int'(ex_rs1));
    e.fb  = youngest(int'(ex_rs2));
    e.st2 = stall_exp(2);
    e.st3 = stall_exp(3);
    e.he2 = m_he2;
    e.he3 = m_he3;
    e.sc2 = m_sc2;
    e.sc3 = m_sc3;
    e.fc  = m_fc;
    expq.push_back(e);
  endtask

  task automatic step(input bit adv, input bit fl, input bit ev, input bit ew, input bit el,
                      input int erd, input int ers1, input int ers2,
                      input bit iv, input int ir1, input int ir2);
    @(posedge clk);
    model_edge();
    #1;
    advance      = adv;
    flush        = fl;
    ex_valid     = ev;
    ex_reg_write = ew;
    ex_is_load   = el;
    ex_rd        = 4'(erd);
    ex_rs1       = 4'(ers1);
    ex_rs2       = 4'(ers2);
    id_valid     = iv;
    id_rs1       = 4'(ir1);
    id_rs2       = 4'(ir2);
    push_exp();
  endtask

  task automatic bubble(input bit iv, input int ir1, input int ir2);
    step(1, 0, 0, 0, 0, 0, 0, 0, iv, ir1, ir2);
  endtask

  task automatic drain();
    repeat (NF) bubble(0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_stall_l2", st2, 0);
    check("rst_stall_l3", st3, 0);
    check("rst_fwd_a_l3", fa3, 0);
    check("rst_fwd_b_l3", fb3, 0);
    check("rst_herr_l3", he3, 0);
    check("rst_scnt_l3", sc3, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("fwd_a_l2", fa2, e.fa);
        check("fwd_b_l2", fb2, e.fb);
        check("fwd_a_l3", fa3, e.fa);
        check("fwd_b_l3", fb3, e.fb);
        check("stall_l2", st2, e.st2);
        check("stall_l3", st3, e.st3);
        check("herr_l2", he2, e.he2);
        check("herr_l3", he3, e.he3);
        check("scnt_l2", sc2, e.sc2);
        check("scnt_l3", sc3, e.sc3);
        check("fcnt_l2", fc2, e.fc);
        check("fcnt_l3", fc3, e.fc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    {advance, flush, ex_valid, ex_reg_write, ex_is_load, id_valid} = '0;
    {ex_rd, ex_rs1, ex_rs2, id_rs1, id_rs2} = '0;
    model_reset();
    #22;
    check("reset_fwd_a", fa2, 0);
    check("reset_stall", st2, 0);
    check("reset_herr", he2, 0);
    check("reset_fcnt", fc2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU writes r3, consumer reads it from slot 1.
    step(1, 0, 1, 1, 0, 3, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 6, 3, 0, 0, 0, 0);
    #2 check("alu_fwd_a", fa2, 1);
    check("alu_fwd_b", fb2, 0);
    check("alu_stall", st2, 0);

    // r5 in slots 1 and 2; then with slot 1 flushed.
    drain();
    step(1, 0, 1, 1, 0, 5, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 5, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0);
    #2 check("prio_youngest", fa2, 1);
    drain();
    step(1, 0, 1, 1, 0, 5, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0);
    #2 check("prio_flushed", fa2, 2);

    // Load-use on rs2, one bubble, dependent forwards from slot 2.
    drain();
    step(1, 0, 1, 1, 1, 4, 0, 0, 1, 0, 4);
    #2 check("lu_stall0_l2", st2, 1);
    check("lu_stall0_l3", st3, 1);
    bubble(1, 0, 4);
    #2 check("lu_stall1_l2", st2, 0);
    check("lu_stall1_l3", st3, 1);
    step(1, 0, 1, 0, 0, 0, 0, 4, 0, 0, 0);
    #2 check("lu_fwd_b_slot2", fb2, 2);
    bubble(0, 0, 0);
    #2 check("lu_herr_l2", he2, 0);
    check("lu_herr_l3", he3, 1);

    // Load ready at slot 3: two stall cycles, dependent forwards from slot 3.
    drain();
    step(1, 0, 1, 1, 1, 4, 0, 0, 1, 4, 0);
    #2 check("l3_stall0", st3, 1);
    bubble(1, 4, 0);
    #2 check("l3_stall1", st3, 1);
    bubble(1, 4, 0);
    #2 check("l3_stall2", st3, 0);
    step(1, 0, 1, 0, 0, 0, 4, 0, 0, 0, 0);
    #2 check("l3_fwd_a_slot3", fa3, 3);

    // Younger ALU write to r4 masks the older load.
    drain();
    step(1, 0, 1, 1, 1, 4, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 4, 0, 0, 1, 4, 0);
    #2 check("mask_ex1_l3", st3, 0);
    bubble(1, 4, 0);
    #2 check("mask_slot1_l3", st3, 0);

    // Zero register is never forwarded.
    drain();
    step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 check("zero_reg_fwd", fa2, 0);

    // Freeze: first edge still commits the reader, then slots hold for four more edges.
    drain();
    step(1, 0, 1, 1, 0, 2, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1, 0, int'($urandom_range(1, 3)), 2, 0, 0, 0, 0);
      #2 check("freeze_fwd_a", fa2, 2);
    end

    // Reset in the middle of a stall.
    drain();
    step(1, 0, 1, 1, 1, 4, 0, 0, 1, 4, 4);
    #2 check("pre_rst_stall", st3, 1);
    do_reset();

    // Forced hazard with load ready at slot 2, flag stays set.
    drain();
    step(1, 0, 1, 1, 1, 4, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 4, 0, 0, 0, 0);
    bubble(0, 0, 0);
    #2 check("herr_set_l2", he2, 1);
    repeat (3) bubble(0, 0, 0);
    #2 check("herr_sticky_l2", he2, 1);

`ifdef FWD_PERF_EN
    // Three single-cycle load-use stalls for ready-slot 2 (two each for ready-slot 3).
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 1, 1, 1, i, 0, 0, 1, i, 0);
      bubble(1, i, 0);
      bubble(0, 0, 0);
    end
    #2 check("perf_stall_l2", sc2, 3);
    check("perf_stall_l3", sc3, 6);
`endif

    // Randomised traffic over a small register set to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if (i == 1500) do_reset();
    end

    @(negedge clk);
    #1;
    check("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
